multicycle_main_control: RTL and testbench

Moore-style main control state machine for the multicycle datapath. Each instruction is sequenced through fetch, decode, execute, memory and writeback steps, and the FSM drives every datapath enable and mux select. It produces the 2-bit `aluop` code that the ALU control decoder consumes: 00 = add, 01 = subtract, 10 = decode funct. It sits between the instruction register opcode field and the datapath, and stalls on a memory ready handshake.

---
 rtl/multicycle_main_control.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle datapath (Moore-style).
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select.
// Optional feature: define MULTICYCLE_ADDI_EN to support addi (opcode 001000).
module multicycle_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [3:0] ADDIEX = 4'd10;
    localparam logic [3:0] ADDIWB = 4'd11;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    logic [3:0] state_q, state_d;

    // State register; reset forces FETCH immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // Moore outputs per state; irwrite/pcwrite/illegal_op also look at inputs.
    always_comb begin
        aluop       = 2'b00;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: begin
                // Branch target is precomputed while the opcode decodes.
                alusrcb = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI: illegal_op = 1'b0;
`endif
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
`ifdef MULTICYCLE_ADDI_EN
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: random instruction stream
// with random memory wait states, checked against an instruction-level model.
// Build with MULTICYCLE_ADDI_EN defined to expect addi support.
module tb_multicycle_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, illegal_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    multicycle_main_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .aluop       (aluop),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsource    (pcsource),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .illegal_op  (illegal_op),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: each instruction is a list of step numbers;
    // steps 0, 3 and 5 wait for mem_ready.
    int         seq[$];
    int         pos;
    logic [5:0] cur_op;

    function automatic bit op_legal(input logic [5:0] op);
        logic [5:0] legal[$];
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
`ifdef MULTICYCLE_ADDI_EN
        legal.push_back(6'b001000);
`endif
        foreach (legal[i]) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic new_instr();
        int pick;
        pick = $urandom_range(0, 7);
        case (pick)
            0: cur_op = 6'b000000;
            1: cur_op = 6'b100011;
            2: cur_op = 6'b101011;
            3: cur_op = 6'b000100;
            4: cur_op = 6'b000010;
            5: cur_op = 6'b001000;
            6: cur_op = 6'b111111;
            default: cur_op = 6'($urandom);
        endcase
        opcode = cur_op;
        if (!op_legal(cur_op))         seq = '{0, 1};
        else if (cur_op == 6'b000000)  seq = '{0, 1, 6, 7};
        else if (cur_op == 6'b100011)  seq = '{0, 1, 2, 3, 4};
        else if (cur_op == 6'b101011)  seq = '{0, 1, 2, 5};
        else if (cur_op == 6'b000100)  seq = '{0, 1, 8};
        else if (cur_op == 6'b000010)  seq = '{0, 1, 9};
        else                           seq = '{0, 1, 10, 11};
        pos = 0;
    endtask

    task automatic advance(input logic mr);
        int st;
        st = seq[pos];
        if ((st == 0 || st == 3 || st == 5) && !mr) return;
        pos++;
        if (pos == seq.size()) new_instr();
    endtask

    // Expected control vector:
    // {aluop, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, iord, memread,
    //  memwrite, irwrite, memtoreg, regdst, regwrite, illegal_op}
    function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
        logic [1:0] a_op = 2'b00, srcb = 2'b00, pcs = 2'b00;
        logic srca = 0, pcw = 0, pcwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, ill = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; ill = !op_legal(op); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; io = 1; end
            6:  begin srca = 1; a_op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; a_op = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; end
            default: begin end
        endcase
        return {a_op, srca, srcb, pcs, pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, ill};
    endfunction

    function automatic logic [16:0] dut_ctrl();
        return {aluop, alusrca, alusrcb, pcsource, pcwrite, pcwritecond, iord, memread,
                memwrite, irwrite, memtoreg, regdst, regwrite, illegal_op};
    endfunction

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        #3;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_ctrl_mr1", 32'(dut_ctrl()), 32'(exp_ctrl(0, 1'b1, opcode)));
        mem_ready = 1'b0;
        #1;
        check("reset_ctrl_mr0", 32'(dut_ctrl()), 32'(exp_ctrl(0, 1'b0, opcode)));

        @(negedge clk);
        rst_n = 1'b1;
        new_instr();

        for (int cyc = 0; cyc < 600; cyc++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            check($sformatf("state_c%0d", cyc), 32'(state_o), 32'(seq[pos]));
            check($sformatf("ctrl_c%0d_s%0d", cyc, seq[pos]), 32'(dut_ctrl()),
                  32'(exp_ctrl(seq[pos], mem_ready, cur_op)));
            check($sformatf("rd_wr_excl_c%0d", cyc), 32'(memread & memwrite), 32'd0);
            check($sformatf("rw_mw_excl_c%0d", cyc), 32'(regwrite & memwrite), 32'd0);
            @(posedge clk);
            #1;
            advance(mem_ready);
            @(negedge clk);
        end

        // Asynchronous reset while parked in MEMWR.
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sw_in_memwr", 32'(state_o), 32'd5);
        check("sw_memwrite", 32'(memwrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_memwrite", 32'(memwrite), 32'd0);
        check("async_rst_memread", 32'(memread), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
